// File: rtl/ram_arbiter_if.sv
// One DMA requester port of the main-RAM arbiter: held request, single-cycle ack,
// and read data returned with rvalid on the cycle after a read ack.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port main RAM between the 6502 (top priority on enable cycles)
// and two round-robin DMA ports; acks are same-cycle, read data arrives one cycle later.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic                  cpu_clken,
    input  logic                  cpu_cs,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    ram_arbiter_if.slave          a_port,
    ram_arbiter_if.slave          b_port,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    typedef enum logic {TURN_A = 1'b0, TURN_B = 1'b1} turn_t;

    turn_t                 turn_q, turn_d;
    logic                  cpu_slot, grant_a, grant_b;
    logic                  cpu_pend_q, a_pend_q, b_pend_q;
    logic [DATA_WIDTH-1:0] cpu_hold_q, a_hold_q, b_hold_q;

    always_comb begin
        cpu_slot = cpu_clken & cpu_cs & ~rst;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        turn_d   = turn_q;
        if (!rst && !cpu_slot) begin
            if (a_port.req && (!b_port.req || turn_q == TURN_A)) begin
                grant_a = 1'b1;
            end else if (b_port.req) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) turn_d = TURN_B;
        if (grant_b) turn_d = TURN_A;
    end

    // Idle and CPU slots both present the CPU bus, so the RAM never sees an undriven address.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_wdata;
        ram_we   = cpu_slot & cpu_we;
        if (grant_a) begin
            ram_addr = a_port.addr;
            ram_din  = a_port.wdata;
            ram_we   = a_port.we;
        end else if (grant_b) begin
            ram_addr = b_port.addr;
            ram_din  = b_port.wdata;
            ram_we   = b_port.we;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            turn_q     <= TURN_A;
            cpu_pend_q <= 1'b0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            cpu_hold_q <= '0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            turn_q     <= turn_d;
            cpu_pend_q <= cpu_slot & ~cpu_we;
            a_pend_q   <= grant_a & ~a_port.we;
            b_pend_q   <= grant_b & ~b_port.we;
            if (cpu_pend_q) cpu_hold_q <= ram_dout;
            if (a_pend_q)   a_hold_q   <= ram_dout;
            if (b_pend_q)   b_hold_q   <= ram_dout;
        end
    end

    // RAM output is forwarded on the return cycle and latched so later DMA traffic cannot disturb it.
    assign cpu_rdata     = rst ? '0 : (cpu_pend_q ? ram_dout : cpu_hold_q);
    assign a_port.ack    = grant_a;
    assign a_port.rvalid = a_pend_q & ~rst;
    assign a_port.rdata  = rst ? '0 : (a_pend_q ? ram_dout : a_hold_q);
    assign b_port.ack    = grant_b;
    assign b_port.rvalid = b_pend_q & ~rst;
    assign b_port.rdata  = rst ? '0 : (b_pend_q ? ram_dout : b_hold_q);
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a
// slot-level reference model and a behavioural registered-read RAM.
module tb_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int S_IDLE = 0;
    localparam int S_CPU  = 1;
    localparam int S_A    = 2;
    localparam int S_B    = 3;

    logic          clk25 = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_clken = 1'b0, cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    always #5 clk25 = ~clk25;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk25(clk25), .rst(rst),
        .cpu_clken(cpu_clken), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .a_port(a_if), .b_port(b_if),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Registered-read single-port RAM standing in for the real ram instance.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk25) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory contents, what each reader should currently see, fairness history.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] exp_cpu_rd = '0, exp_a_rd = '0, exp_b_rd = '0;
    logic          exp_a_rv = 1'b0, exp_b_rv = 1'b0;
    int            last_dma = S_B;
    int            slot = S_IDLE;
    int            a_wait = 0, b_wait = 0;
    int            obs_a_acks = 0, obs_b_acks = 0;
    logic          obs_a_ack, obs_b_ack, obs_b_rv, obs_a_rv;
    logic [DW-1:0] obs_cpu_rd, obs_a_rd, obs_b_rd;
    logic [AW-1:0] obs_ram_addr;

    task automatic step();
        logic          e_we, e_aack, e_back;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        @(negedge clk25);
        if (rst)                          slot = S_IDLE;
        else if (cpu_clken && cpu_cs)     slot = S_CPU;
        else if (a_if.req && b_if.req)    slot = (last_dma == S_A) ? S_B : S_A;
        else if (a_if.req)                slot = S_A;
        else if (b_if.req)                slot = S_B;
        else                              slot = S_IDLE;

        e_we = 1'b0; e_addr = cpu_addr; e_din = cpu_wdata; e_aack = 1'b0; e_back = 1'b0;
        case (slot)
            S_CPU: e_we = cpu_we;
            S_A: begin e_we = a_if.we; e_addr = a_if.addr; e_din = a_if.wdata; e_aack = 1'b1; end
            S_B: begin e_we = b_if.we; e_addr = b_if.addr; e_din = b_if.wdata; e_back = 1'b1; end
            default: ;
        endcase

        check("ram_we", ram_we, e_we);
        check("ram_addr", ram_addr, e_addr);
        check("ram_din", ram_din, e_din);
        check("a_ack", a_if.ack, e_aack);
        check("b_ack", b_if.ack, e_back);
        check("a_rvalid", a_if.rvalid, rst ? 1'b0 : exp_a_rv);
        check("b_rvalid", b_if.rvalid, rst ? 1'b0 : exp_b_rv);
        check("cpu_rdata", cpu_rdata, rst ? '0 : exp_cpu_rd);
        check("a_rdata", a_if.rdata, rst ? '0 : exp_a_rd);
        check("b_rdata", b_if.rdata, rst ? '0 : exp_b_rd);

        obs_a_ack = a_if.ack;   obs_b_ack = b_if.ack;
        obs_a_rv = a_if.rvalid; obs_b_rv = b_if.rvalid;
        obs_cpu_rd = cpu_rdata; obs_a_rd = a_if.rdata; obs_b_rd = b_if.rdata;
        obs_ram_addr = ram_addr;
        if (a_if.ack === 1'b1) obs_a_acks++;
        if (b_if.ack === 1'b1) obs_b_acks++;

        if (!rst && a_if.req) begin
            if (a_if.ack === 1'b1) begin check("a_starve", a_wait <= 3, 1'b1); a_wait = 0; end
            else a_wait++;
        end else a_wait = 0;
        if (!rst && b_if.req) begin
            if (b_if.ack === 1'b1) begin check("b_starve", b_wait <= 3, 1'b1); b_wait = 0; end
            else b_wait++;
        end else b_wait = 0;

        @(posedge clk25);
        exp_a_rv = 1'b0;
        exp_b_rv = 1'b0;
        if (rst) begin
            exp_cpu_rd = '0; exp_a_rd = '0; exp_b_rd = '0;
            last_dma = S_B;
        end else begin
            case (slot)
                S_CPU: if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                       else        exp_cpu_rd = ref_mem[cpu_addr];
                S_A: begin
                    last_dma = S_A;
                    if (a_if.we) ref_mem[a_if.addr] = a_if.wdata;
                    else begin exp_a_rv = 1'b1; exp_a_rd = ref_mem[a_if.addr]; end
                end
                S_B: begin
                    last_dma = S_B;
                    if (b_if.we) ref_mem[b_if.addr] = b_if.wdata;
                    else begin exp_b_rv = 1'b1; exp_b_rd = ref_mem[b_if.addr]; end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic cpu_set(input logic en, input logic cs, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        cpu_clken = en; cpu_cs = cs; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return '1;
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        logic prev_en;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;

        // Reset then idle.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // CPU read under continuous port A write load.
        cpu_set(1, 1, 1, 15'h0123, 8'h5A); step();
        cpu_set(0, 0, 0, 15'h0000, 8'h00); step();
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 15'h0200; a_if.wdata = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            cpu_set((i % 4) == 0, 1, 0, 15'h0123, 8'h00);
            step();
            if (i % 4 == 0) begin
                check("cpu_rd_addr", obs_ram_addr, 15'h0123);
                check("a_ack_on_en", obs_a_ack, 1'b0);
            end
            if (i >= 1) check("cpu_rd_held", obs_cpu_rd, 8'h5A);
        end
        a_if.req = 1'b0;
        cpu_set(0, 0, 0, 15'h0000, 8'h00);
        step();

        // Round robin from reset with both ports saturating.
        rst = 1'b1; step(); rst = 1'b0;
        obs_a_acks = 0; obs_b_acks = 0;
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 15'h1000; a_if.wdata = 8'h01;
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 15'h2000; b_if.wdata = 8'h02;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i < 4) check("rr_order", obs_a_ack, (i % 2) == 0);
            if (obs_a_ack) begin a_if.addr = a_if.addr + 1'b1; a_if.wdata = a_if.wdata + 1'b1; end
            if (obs_b_ack) begin b_if.addr = b_if.addr + 1'b1; b_if.wdata = b_if.wdata + 1'b1; end
        end
        check("rr_balance", (obs_a_acks - obs_b_acks <= 1) && (obs_b_acks - obs_a_acks <= 1), 1'b1);
        check("rr_total", obs_a_acks + obs_b_acks, 100);
        a_if.req = 1'b0; b_if.req = 1'b0;

        // Port B read at the top of RAM.
        cpu_set(1, 1, 1, 15'h7FFF, 8'hC3); step();
        cpu_set(0, 0, 0, 15'h0000, 8'h00);
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 15'h7FFF;
        step();
        check("b_ack_t", obs_b_ack, 1'b1);
        b_if.req = 1'b0;
        step();
        check("b_rvalid_t1", obs_b_rv, 1'b1);
        check("b_rdata_t1", obs_b_rd, 8'hC3);
        check("a_rvalid_quiet", obs_a_rv, 1'b0);
        step();
        check("b_rvalid_t2", obs_b_rv, 1'b0);

        // CPU and port A write the same address in the same enable cycle.
        cpu_set(1, 1, 1, 15'h0010, 8'h11);
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 15'h0010; a_if.wdata = 8'h22;
        step();
        check("wc_cpu_wins", obs_a_ack, 1'b0);
        cpu_set(0, 0, 0, 15'h0000, 8'h00);
        step();
        check("wc_a_next", obs_a_ack, 1'b1);
        a_if.req = 1'b0;
        cpu_set(1, 1, 0, 15'h0010, 8'h00); step();
        cpu_set(0, 0, 0, 15'h0000, 8'h00); step();
        check("wc_final", obs_cpu_rd, 8'h22);

        // Reset asserted right after a port A read ack, with port B waiting.
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 15'h0123;
        step();
        check("rm_a_ack", obs_a_ack, 1'b1);
        a_if.req = 1'b0;
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 15'h0300; b_if.wdata = 8'h77;
        rst = 1'b1;
        step();
        check("rm_a_rvalid", obs_a_rv, 1'b0);
        check("rm_a_rdata", obs_a_rd, 8'h00);
        check("rm_b_ack", obs_b_ack, 1'b0);
        rst = 1'b0;
        step();
        check("rm_b_first", obs_b_ack, 1'b1);
        b_if.req = 1'b0;
        step();

        // Randomized traffic; enables never on consecutive cycles.
        prev_en = 1'b0;
        for (int i = 0; i < 500; i++) begin
            logic en;
            en = prev_en ? 1'b0 : ($urandom_range(0, 2) == 0);
            prev_en = en;
            cpu_set(en, $urandom_range(0, 3) != 0, $urandom_range(0, 1), rand_addr(), DW'($urandom));
            if (!a_if.req && $urandom_range(0, 2) != 0) begin
                a_if.req = 1'b1; a_if.we = $urandom_range(0, 1); a_if.addr = rand_addr(); a_if.wdata = DW'($urandom);
            end
            if (!b_if.req && $urandom_range(0, 2) != 0) begin
                b_if.req = 1'b1; b_if.we = $urandom_range(0, 1); b_if.addr = rand_addr(); b_if.wdata = DW'($urandom);
            end
            step();
            if (slot == S_A) begin
                a_if.req = $urandom_range(0, 1); a_if.we = $urandom_range(0, 1);
                a_if.addr = rand_addr(); a_if.wdata = DW'($urandom);
            end
            if (slot == S_B) begin
                b_if.req = $urandom_range(0, 1); b_if.we = $urandom_range(0, 1);
                b_if.addr = rand_addr(); b_if.wdata = DW'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port main RAM (0x0000-0x7FFF) between the 6502 and two DMA requesters, port A (UART bootloader) and port B (memory viewer/debug).
- The CPU gets fixed top priority on its enabled cycles. DMA ports round-robin on every other cycle.
- Because DMA traffic disturbs the RAM output register between CPU cycles, read data for the CPU is captured and held stable for the CPU's next enabled edge.
- Sits between the CPU bus / chip-select decode and the ram instance.

Parameters:
- ADDR_WIDTH, 15, RAM word address width.
- DATA_WIDTH, 8, data width.

Ports:
- clk25  in  1  master clock.
- rst  in  1  synchronous reset, active-high.
- cpu_clken  in  1  CPU enable strobe; never high on two consecutive cycles.
- cpu_cs  in  1  CPU address decodes to RAM.
- cpu_we  in  1  CPU write.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  held CPU read data.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A write.
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_ack  out  1  port A access performed this cycle.
- a_rvalid  out  1  a_rdata valid (one cycle after a read ack).
- a_rdata  out  DATA_WIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as port A, for port B.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_we  out  1  to RAM write enable.
- ram_din  out  DATA_WIDTH  to RAM write data.
- ram_dout  in  DATA_WIDTH  RAM registered read data (1-cycle latency).

Behaviour:
- Slot decision is combinational each cycle. Priority order:
  1. CPU slot when cpu_clken & cpu_cs.
  2. Otherwise a single DMA requester, if only one is requesting.
  3. Otherwise, both requesting: grant the port not granted last. The rr pointer is updated on each DMA grant; reset value is A-first.
  4. Otherwise idle.
- A cycle with cpu_clken=1 and cpu_cs=0 is a free DMA slot.
- CPU slot: ram_addr=cpu_addr, ram_din=cpu_wdata, ram_we=cpu_we; a_ack=b_ack=0.
- DMA slot for port X: ram_addr/ram_din/ram_we from port X; X_ack=1 combinationally in that cycle.
- Idle slot: ram_we=0, ram_addr=cpu_addr, ram_din=cpu_wdata.
- cpu_rdata: register, captures ram_dout on the cycle after a CPU read slot; otherwise holds. It is unaffected by DMA traffic and by CPU writes.
- X_rdata/X_rvalid:
  - On the cycle after a port X read ack: X_rvalid=1 for exactly one cycle and X_rdata<=ram_dout.
  - X_rdata holds otherwise.
  - Write acks never raise X_rvalid.
- Back-to-back acks to the same port are allowed when only that port requests (a new ack every cycle). Requester must change address/data after each ack or drop req.
- Starvation: each DMA port is served within 3 cycles of request when both are active, given the cpu_clken spacing. The bench checks this bound.
- Reset (rst=1):
  - All acks and rvalids 0; ram_we=0 (including the reset cycle itself).
  - cpu_rdata=0, a_rdata=b_rdata=0, rr pointer=A.
  - A request pending at reset is not acked until the first post-reset cycle.
  - An rvalid due the cycle after reset is suppressed.
- Simultaneous events:
  - CPU slot plus both DMA requests: CPU wins and the rr pointer is unchanged.
  - A CPU capture and a DMA rvalid never coincide with the same data source, because at most one slot occurs per cycle.
- No X/undefined on outputs: all muxes default to the CPU path.

Test Plan:
- Reset then idle, rst=1 for 2 cycles: all acks/rvalid 0, ram_we=0, cpu_rdata=0x00, a_rdata=b_rdata=0x00.
- CPU read under DMA load:
  - Stimulus: RAM[0x0123]=0x5A; CPU reads 0x0123 at cpu_clken (1-of-4 cycles) while port A writes 0xFF to 0x0200 continuously.
  - Response: ram_addr=0x0123 on the enable cycle; cpu_rdata=0x5A from the next cycle, held until the next CPU read; a_ack never high on enable cycles.
- Round robin:
  - Stimulus: a_req and b_req held, cpu_cs=0.
  - Response: acks alternate A,B,A,B from reset, A first; each port's ack count differs by at most 1 over 100 cycles.
- DMA read latency:
  - Stimulus: port B reads 0x7FFF containing 0xC3.
  - Response: b_ack in cycle t; b_rvalid=1 and b_rdata=0xC3 in t+1 only; a_rvalid stays 0.
- Write conflict:
  - Stimulus: CPU write 0x11 to 0x0010 and port A write 0x22 to 0x0010 in the same enable cycle.
  - Response: CPU wins that cycle; A acked next cycle; final RAM[0x0010]=0x22.
- Reset mid-operation:
  - Stimulus: assert rst in the cycle after an A read ack.
  - Response: a_rvalid stays 0, a_rdata=0, no ram_we; pending b_req is acked first cycle after rst deasserts.
